multicycle_control: RTL



---
 rtl/multicycle_control.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle ARM-subset core. Sequences each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath enables and the 2-bit ALUOp.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        alu_zero,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_op_sel,
    output logic        alu_src_b,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        flags_write,
    output logic        trap,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StWb     = 3'd3,
        StAddr   = 3'd4,
        StMem    = 3'd5,
        StBranch = 3'd6,
        StTrap   = 3'd7
    } state_e;

    // MOVZ/ADDI/SUBI share one class: they sequence identically.
    typedef enum logic [2:0] {
        OpNone = 3'd0,
        OpAlu  = 3'd1,
        OpCmp  = 3'd2,
        OpLdur = 3'd3,
        OpStur = 3'd4,
        OpCbz  = 3'd5,
        OpB    = 3'd6
    } op_e;

    // Opcode constants, each compared against its own top-of-word field width.
    localparam logic [7:0]  OpcCbz  = 8'hB4;   // [31:24]
    localparam logic [5:0]  OpcB    = 6'h05;   // [31:26]
    localparam logic [10:0] OpcMovz = 11'h694; // [31:21]
    localparam logic [7:0]  OpcCmp  = 8'hEB;   // [31:24]
    localparam logic [8:0]  OpcSubi = 9'h1A2;  // [31:23]
    localparam logic [8:0]  OpcAddi = 9'h122;  // [31:23]
    localparam logic [10:0] OpcLdur = 11'h7C2; // [31:21]
    localparam logic [10:0] OpcStur = 11'h7C0; // [31:21]

    localparam logic [CNT_W-1:0] CntLimit = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    op_e              dec_class;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;

    // Operand fields are consumed by the datapath, not by this controller.
    logic unused_instr;
    assign unused_instr = ^instruction[20:0];

    assign state = state_q;

    // Classify the IR contents; earlier tests take priority where patterns overlap.
    always_comb begin
        dec_class = OpNone;
        if (instruction[31:24] == OpcCbz) begin
            dec_class = OpCbz;
        end else if (instruction[31:26] == OpcB) begin
            dec_class = OpB;
        end else if (instruction[31:21] == OpcMovz) begin
            dec_class = OpAlu;
        end else if (instruction[31:24] == OpcCmp) begin
            dec_class = OpCmp;
        end else if (instruction[31:23] == OpcSubi) begin
            dec_class = OpAlu;
        end else if (instruction[31:23] == OpcAddi) begin
            dec_class = OpAlu;
        end else if (instruction[31:21] == OpcLdur) begin
            dec_class = OpLdur;
        end else if (instruction[31:21] == OpcStur) begin
            dec_class = OpStur;
        end
    end

    // Next state, latched op class and wait counter.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        waiting = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    state_d = StDecode;
                end else begin
                    waiting = 1'b1;
                    if (cnt_q == CntLimit) state_d = StTrap;
                end
            end
            StDecode: begin
                op_d = dec_class;
                case (dec_class)
                    OpAlu, OpCmp:  state_d = StExec;
                    OpLdur, OpStur: state_d = StAddr;
                    OpCbz, OpB:    state_d = StBranch;
                    default:       state_d = StTrap;
                endcase
            end
            StExec:   state_d = (op_q == OpCmp) ? StFetch : StWb;
            StWb:     state_d = StFetch;
            StAddr:   state_d = StMem;
            StMem: begin
                if (dmem_ready) begin
                    state_d = (op_q == OpLdur) ? StWb : StFetch;
                end else begin
                    waiting = 1'b1;
                    if (cnt_q == CntLimit) state_d = StTrap;
                end
            end
            StBranch: state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StTrap;
        endcase

        // Counter restarts on every transition and saturates rather than wrapping.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntOne;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, op-class and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            op_q    <= OpNone;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs of state/op class, plus ready/alu_zero gating; forced low during reset
    // so a pending request is dropped in the same cycle reset asserts.
    always_comb begin
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        alu_op_sel  = 2'b00;
        alu_src_b   = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        flags_write = 1'b0;
        trap        = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = 2'b00;
                    end
                end
                StDecode: begin
                end
                StExec: begin
                    alu_op_sel  = 2'b10;
                    alu_src_b   = (op_q != OpCmp);
                    flags_write = (op_q == OpCmp);
                end
                StWb: begin
                    alu_op_sel = 2'b10;
                    reg_write  = 1'b1;
                    mem_to_reg = (op_q == OpLdur);
                end
                StAddr: begin
                    alu_op_sel = 2'b00;
                    alu_src_b  = 1'b1;
                end
                StMem: begin
                    dmem_req = 1'b1;
                    dmem_we  = (op_q == OpStur);
                end
                StBranch: begin
                    alu_op_sel = 2'b01;
                    if (op_q == OpCbz) begin
                        pc_src   = 2'b01;
                        pc_write = alu_zero;
                    end else if (op_q == OpB) begin
                        pc_src   = 2'b10;
                        pc_write = 1'b1;
                    end
                end
                StTrap: begin
                    trap = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
